// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory-port arbiter.
//   arb_state_t  : arbiter sequencing state (IDLE -> ACCESS -> RESP -> IDLE)
//   owner_t      : which core port owns the access in flight
//   MEM_LAT_MAX  : largest supported memory latency (limited by the 4-bit wait counter)
//   lat_load()   : countdown preload value for a given memory latency
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int CNT_W       = 4;
    localparam int MEM_LAT_MAX = 15;

    // The counter runs from MEM_LAT-1 down to 0, so ACCESS lasts MEM_LAT cycles.
    // Out-of-range latencies are clamped rather than wrapping the 4-bit counter.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int l;
        l = (lat > MEM_LAT_MAX) ? MEM_LAT_MAX : ((lat < 1) ? 1 : lat);
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit load/decrement countdown that times the ACCESS phase.
//   clk      in  : rising-edge clock
//   reset    in  : synchronous, active-high; clears the count
//   load     in  : load load_val (has priority over dec)
//   load_val in  : preload value
//   dec      in  : decrement by one; saturates at zero
//   zero     out : count is zero (combinational from the count register)
module mem_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// instruction-fetch port and the load/store data port, and stalls the core while
// either port has an access outstanding.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   if_req/if_addr             fetch request (held until if_ack)
//   if_rdata/if_ack            fetched word (held after ack) / one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata  data request, 1=store (held until d_ack)
//   d_rdata/d_ack              load data (held after ack) / one-cycle done pulse
//   mem_en/mem_we              memory strobe / write enable (mem_we implies mem_en)
//   mem_addr/mem_wdata         latched address / store data of the current access
//   mem_rdata                  memory read data, valid in the last ACCESS cycle
//   stall                      (if_req & ~if_ack) | (d_req & ~d_ack)
//
// Build option
//   ARB_ROUND_ROBIN_EN: when defined, a conflict goes to the port that did not win
//   the previous grant; otherwise data always beats fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    owner_t            owner_reg;
    owner_t            grant_owner;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              any_req;
    logic              grant;
    logic              cnt_zero;
    logic              last_access;

    assign any_req     = if_req | d_req;
    // Requests are only looked at in IDLE; anything seen elsewhere waits its turn.
    assign grant       = (state_reg == IDLE) && any_req;
    assign last_access = (state_reg == ACCESS) && cnt_zero;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // owner_reg already remembers the previous grant (reset value: data), so it
    // doubles as the last-owner record; the first conflict after reset goes to fetch.
    always_comb begin
        grant_owner = OWN_IF;
        if (if_req && d_req) begin
            grant_owner = (owner_reg == OWN_D) ? OWN_IF : OWN_D;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end
`else
    // Fixed priority: the core never issues a new data request while it is
    // stalled on a fetch, so fetch cannot be starved.
    always_comb begin
        grant_owner = d_req ? OWN_D : OWN_IF;
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (any_req)  state_next = ACCESS;
            ACCESS:  if (cnt_zero) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registered state and latched request)
    // ------------------------------------------------------------------
    always_comb begin
        mem_en = (state_reg == ACCESS);
        mem_we = (state_reg == ACCESS) && we_reg;
        if_ack = (state_reg == RESP) && (owner_reg == OWN_IF);
        d_ack  = (state_reg == RESP) && (owner_reg == OWN_D);
    end

    // ------------------------------------------------------------------
    // Request latch and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg    <= OWN_D;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            if (grant) begin
                owner_reg <= grant_owner;
                if (grant_owner == OWN_D) begin
                    we_reg    <= d_we;
                    addr_reg  <= d_addr;
                    wdata_reg <= d_wdata;
                end else begin
                    // Fetches never write; mem_wdata keeps the last store data.
                    we_reg    <= 1'b0;
                    addr_reg  <= if_addr;
                end
            end
            // Stores leave d_rdata untouched.
            if (last_access && !we_reg) begin
                if (owner_reg == OWN_IF) begin
                    if_rdata_reg <= mem_rdata;
                end else begin
                    d_rdata_reg  <= mem_rdata;
                end
            end
        end
    end

    mem_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (grant),
        .load_val (lat_load(MEM_LAT)),
        .dec      (state_reg == ACCESS),
        .zero     (cnt_zero)
    );

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Instance a uses MEM_LAT=2 for the
// directed cases, instance b uses MEM_LAT=1 for a random sweep; sel routes the
// shared stimulus and observation to one instance at a time. Memory models
// return {2'b00, ~addr} only in the final cycle of a strobe run.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;

    typedef struct {
        bit            port;   // 0 = fetch, 1 = data
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    // instance a (MEM_LAT=2)
    logic [DW-1:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0] a_mem_addr;
    logic          a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_stall;
    int            a_en_cnt = 0;
    // instance b (MEM_LAT=1)
    logic [DW-1:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;
    logic          b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_stall;
    int            b_en_cnt = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req & ~sel), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .d_req(d_req & ~sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(a_d_rdata), .d_ack(a_d_ack),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .stall(a_stall)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .if_req(if_req & sel), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .d_req(d_req & sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .stall(b_stall)
    );

    // Fixed-latency memory models: data is only meaningful in the last strobe cycle.
    always @(posedge clk) a_en_cnt <= (reset || !a_mem_en) ? 0 : a_en_cnt + 1;
    always @(posedge clk) b_en_cnt <= (reset || !b_mem_en) ? 0 : b_en_cnt + 1;
    assign a_mem_rdata = (a_mem_en && a_en_cnt == 1) ? {2'b00, ~a_mem_addr} : 32'h5A5A_A5A5;
    assign b_mem_rdata = (b_mem_en && b_en_cnt == 0) ? {2'b00, ~b_mem_addr} : 32'h5A5A_A5A5;

    // Observation of the selected instance
    logic [DW-1:0] if_rdata_m, d_rdata_m_out, mem_wdata_m;
    logic [AW-1:0] mem_addr_m;
    logic          if_ack_m, d_ack_m, mem_en_m, mem_we_m, stall_m;
    assign if_rdata_m    = sel ? b_if_rdata  : a_if_rdata;
    assign d_rdata_m_out = sel ? b_d_rdata   : a_d_rdata;
    assign mem_wdata_m   = sel ? b_mem_wdata : a_mem_wdata;
    assign mem_addr_m    = sel ? b_mem_addr  : a_mem_addr;
    assign if_ack_m      = sel ? b_if_ack    : a_if_ack;
    assign d_ack_m       = sel ? b_d_ack     : a_d_ack;
    assign mem_en_m      = sel ? b_mem_en    : a_mem_en;
    assign mem_we_m      = sel ? b_mem_we    : a_mem_we;
    assign stall_m       = sel ? b_stall     : a_stall;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [DW-1:0] d_rdata_m [2];   // expected held d_rdata per instance
`ifdef ARB_ROUND_ROBIN_EN
    bit            last_d_m [2];    // previous grant went to data
`endif

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got %h, expected %h", name, sel, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on every ack and checks the access that
    // produced it, plus per-cycle invariants.
    // ------------------------------------------------------------------
    int            en_run = 0;
    int            we_run = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            en_run = 0;
            we_run = 0;
        end else begin
            chk("ack_exclusive", 32'(if_ack_m & d_ack_m), 32'd0);
            chk("we_without_en", 32'(mem_we_m & ~mem_en_m), 32'd0);
            if (mem_en_m) begin
                if (en_run == 0) begin
                    cap_addr  = mem_addr_m;
                    cap_wdata = mem_wdata_m;
                end
                en_run++;
                if (mem_we_m) we_run++;
            end
            if (if_ack_m || d_ack_m) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'(d_ack_m), 32'(e.port));
                    chk("mem_addr", 32'(cap_addr), 32'(e.addr));
                    chk("mem_en_cycles", en_run, sel ? 1 : 2);
                    chk("mem_we_cycles", we_run, e.we ? (sel ? 1 : 2) : 0);
                    if (e.port == 1'b0) chk("if_rdata", if_rdata_m, e.rdata);
                    else                chk("d_rdata", d_rdata_m_out, e.rdata);
                    if (e.we) chk("mem_wdata", cap_wdata, e.wdata);
                end
                en_run = 0;
                we_run = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: issue a fetch and/or data request in the same IDLE cycle,
    // push expected responses in expected grant order, then check ack timing
    // and stall cycle by cycle against hand-derived latencies.
    // ------------------------------------------------------------------
    task automatic issue(input bit do_if, input logic [AW-1:0] ia, input bit do_d, input bit we,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd);
        int   lat, t1, t2, t_if, t_d, t_last;
        bit   if_first;
        exp_t e_if, e_d;
        lat = sel ? 1 : 2;
        t1  = lat + 1;            // req-in-IDLE cycle to ack cycle
        t2  = t1 + lat + 2;       // second access of a conflict
        if (do_if && do_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            if_first = last_d_m[sel];
`else
            if_first = 1'b0;
`endif
            t_if   = if_first ? t1 : t2;
            t_d    = if_first ? t2 : t1;
            t_last = t2;
        end else begin
            if_first = do_if;
            t_if     = t1;
            t_d      = t1;
            t_last   = t1;
        end
        e_if.port = 1'b0; e_if.we = 1'b0; e_if.addr = ia; e_if.wdata = '0;
        e_if.rdata = {2'b00, ~ia};
        e_d.port = 1'b1; e_d.we = we; e_d.addr = da; e_d.wdata = wd;
        e_d.rdata = we ? d_rdata_m[sel] : {2'b00, ~da};
        if (do_d) d_rdata_m[sel] = e_d.rdata;
        if (if_first) begin
            sb.push_back(e_if);
            if (do_d) sb.push_back(e_d);
        end else begin
            if (do_d) sb.push_back(e_d);
            if (do_if) sb.push_back(e_if);
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_d_m[sel] = (do_if && do_d) ? if_first : do_d;
`endif
        @(posedge clk); #1;
        if_req = do_if; if_addr = ia;
        d_req = do_d; d_we = we; d_addr = da; d_wdata = wd;
        for (int c = 1; c <= t_last; c++) begin
            @(posedge clk); #1;
            if (c == t_if + 1) if_req = 1'b0;
            if (c == t_d + 1)  d_req = 1'b0;
            chk("if_ack_timing", 32'(if_ack_m), 32'(do_if && c == t_if));
            chk("d_ack_timing", 32'(d_ack_m), 32'(do_d && c == t_d));
            chk("stall", 32'(stall_m), 32'(c < t_last));
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_ack"}, 32'(if_ack_m), 32'd0);
        chk({tag, "_d_ack"}, 32'(d_ack_m), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en_m), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we_m), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_m), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_m, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata_m, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata_m_out, 32'd0);
        chk({tag, "_stall"}, 32'(stall_m), 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            d_rdata_m[i] = '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_m[i] = 1'b1;
`endif
        end
    endtask

    initial begin
        int k;
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // 1. fetch only
        issue(1'b1, 30'h0010_0000, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("if_rdata_held", if_rdata_m, 32'h3FEF_FFFF);
        $display("fetch-only done, if_rdata=%h", if_rdata_m);

        // 2. conflict: load 0x4000 vs fetch
        issue(1'b1, 30'h0000_0200, 1'b1, 1'b0, 30'h0000_4000, '0);
        $display("conflict done, d_rdata=%h if_rdata=%h", d_rdata_m_out, if_rdata_m);

        // 3. store leaves d_rdata alone
        issue(1'b0, '0, 1'b1, 1'b1, 30'h0000_4001, 32'hDEAD_BEEF);
        chk("d_rdata_after_store", d_rdata_m_out, 32'h3FFF_BFFF);
        $display("store done, d_rdata=%h", d_rdata_m_out);

        // 4. reset in the 2nd ACCESS cycle aborts the fetch
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 30'h0000_0123;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_access", 32'(mem_en_m), 32'd1);
        reset = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort");
        model_reset();
        reset = 1'b0;
        issue(1'b1, 30'h0000_0456, 1'b0, 1'b0, '0, '0);
        $display("reset-abort recovery done, if_rdata=%h", if_rdata_m);

        // 5. back-to-back conflicts
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, AW'(30'h0001_0000 + i), 1'b1, i[0], AW'(30'h0002_0000 + i),
                  32'hC0DE_0000 + i);
            $display("conflict %0d done", i);
        end

        // 6. MEM_LAT=1 random sweep
        sel = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            k = $urandom_range(0, 2);
            issue(k != 1, AW'($urandom), k != 0, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
            $display("lat1 txn %0d kind=%0d done", i, k);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
